// File: rtl/mem_bus_ctrl.sv
// Bus-interface stage between the CPU load/store port and the bidirectional-data main memory.
// Sequences enable/read_write/address, owns the data-bus driver and enforces read-to-write turnaround.
`timescale 1ns/1ps

module mem_bus_ctrl #(
    parameter int address_size = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [address_size-1:0] req_addr,
    input  logic [15:0]             req_wdata,
    output logic                    resp_valid,
    output logic [15:0]             resp_rdata,
    output logic                    mem_read_write,
    output logic                    mem_enable,
    output logic [address_size-1:0] mem_address,
    inout  wire  [15:0]             mem_data
);

    typedef enum logic [2:0] {
        IDLE,
        WR,
        RD_ADDR,
        RD_DATA,
        TURN
    } state_e;

    state_e                  state_q;
    logic                    write_q;
    logic [address_size-1:0] addr_q;
    logic [15:0]             wdata_q;
    logic                    enable_q;
    logic                    read_write_q;
    logic                    drive_q;
    logic                    resp_valid_q;
    logic [15:0]             rdata_q;

    assign req_ready      = (state_q == IDLE);
    assign resp_valid     = resp_valid_q;
    assign resp_rdata     = rdata_q;
    assign mem_enable     = enable_q;
    assign mem_read_write = read_write_q;
    assign mem_address    = addr_q;

    // Only a latched store can ever turn the driver on, so a read can never collide with it.
    assign mem_data = (drive_q && write_q) ? wdata_q : 16'hzzzz;

    // NOTE: every register here is assigned with <= so all of them see pre-edge values of each other.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            write_q      <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            enable_q     <= 1'b0;
            read_write_q <= 1'b1;
            drive_q      <= 1'b0;
            resp_valid_q <= 1'b0;
            rdata_q      <= '0;
        end else begin
            resp_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        write_q      <= req_write;
                        addr_q       <= req_addr;
                        wdata_q      <= req_wdata;
                        enable_q     <= 1'b1;
                        read_write_q <= !req_write;
                        drive_q      <= req_write;
                        state_q      <= req_write ? WR : RD_ADDR;
                    end
                end
                WR: begin
                    enable_q     <= 1'b0;
                    read_write_q <= 1'b1;
                    drive_q      <= 1'b0;
                    state_q      <= IDLE;
                end
                RD_ADDR: begin
                    state_q <= RD_DATA;
                end
                RD_DATA: begin
                    // Memory output register is on the bus for this whole cycle.
                    rdata_q      <= mem_data;
                    resp_valid_q <= 1'b1;
                    enable_q     <= 1'b0;
                    state_q      <= TURN;
                end
                TURN: begin
                    state_q <= IDLE;
                end
                default: begin
                    enable_q     <= 1'b0;
                    read_write_q <= 1'b1;
                    drive_q      <= 1'b0;
                    state_q      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Self-checking bench for mem_bus_ctrl: behavioural memory on the shared bus, table-driven
// load/store vectors, a response scoreboard and hand-written reset sequences.
`timescale 1ns/1ps

module tb_mem_bus_ctrl;

    typedef struct {
        logic        write;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] rdata;
    } vec_t;

    typedef struct {
        logic [15:0] data;
        int          cyc;
    } resp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [15:0] req_addr = '0;
    logic [15:0] req_wdata = '0;
    logic        resp_valid;
    logic [15:0] resp_rdata;
    logic        mem_read_write;
    logic        mem_enable;
    logic [15:0] mem_address;
    wire  [15:0] mem_data;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    resp_t       sb_q[$];
    logic [15:0] cur_addr = '0;
    logic [15:0] cur_wdata = '0;
    logic [15:0] last_rdata = '0;
    logic        prev_resp = 1'b0;
    logic        prev_en = 1'b0;

    mem_bus_ctrl #(.address_size(16)) dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_write      (req_write),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .resp_valid     (resp_valid),
        .resp_rdata     (resp_rdata),
        .mem_read_write (mem_read_write),
        .mem_enable     (mem_enable),
        .mem_address    (mem_address),
        .mem_data       (mem_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory: stores at the end of a write cycle, loads its output register every edge and
    // drives it in the cycle after an enabled read cycle. Otherwise, while read_write=1,
    // the bench parks the bus at 0 so a stray controller drive shows up as a nonzero value.
    logic [15:0] mem_arr [0:65535] = '{default: 16'h0000};
    logic [15:0] mem_out_q = '0;
    logic        mem_rd_q = 1'b0;
    wire         mem_drive = mem_enable && mem_read_write && mem_rd_q;

    always @(posedge clk) begin
        if (mem_enable && !mem_read_write) mem_arr[mem_address] <= mem_data;
        mem_out_q <= mem_arr[mem_address];
        mem_rd_q  <= mem_enable && mem_read_write;
    end

    assign mem_data = mem_drive ? mem_out_q : (mem_read_write ? 16'h0000 : 16'hzzzz);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Protocol monitor and scoreboard consumer, sampled on the falling edge.
    always @(negedge clk) begin
        if (!reset) begin
            last_rdata = '0;
            prev_resp  = 1'b0;
            prev_en    = 1'b0;
        end else begin
            if (resp_valid) begin
                check("resp_not_back_to_back", prev_resp, 0);
                if (sb_q.size() == 0) begin
                    check("resp_unexpected", sb_q.size(), 1);
                end else begin
                    resp_t e;
                    e = sb_q.pop_front();
                    check("resp_rdata", resp_rdata, e.data);
                    check("resp_cycle", cyc, e.cyc);
                    last_rdata = e.data;
                end
            end
            check("rdata_hold", resp_rdata, last_rdata);
            if (mem_enable && !mem_read_write) begin
                check("wr_data", mem_data, cur_wdata);
                check("wr_addr", mem_address, cur_addr);
                check("wr_dead_cycle", prev_en, 0);
            end
            if (mem_enable && mem_read_write) check("rd_addr", mem_address, cur_addr);
            if (mem_read_write && !mem_drive) check("bus_released", mem_data, 0);
            if (!mem_enable) check("idle_read_write", mem_read_write, 1);
            prev_resp = resp_valid;
            prev_en   = mem_enable;
        end
    end

    // Issue one request from a falling edge; while busy, hammer the request port with random
    // valid requests that must be ignored, then leave req_valid low only if nothing follows.
    task automatic issue(input vec_t v);
        int          guard = 0;
        int          busy = 0;
        logic [31:0] r1;
        logic [31:0] r2;
        while (!req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check("ready_wait", req_ready, 1);
        req_valid = 1'b1;
        req_write = v.write;
        req_addr  = v.addr;
        req_wdata = v.wdata;
        @(posedge clk);
        #1;
        cur_addr  = v.addr;
        cur_wdata = v.wdata;
        if (!v.write) sb_q.push_back('{data: v.rdata, cyc: cyc + 2});
        r1 = $urandom; r2 = $urandom;
        req_write = r1[16]; req_addr = r1[15:0]; req_wdata = r2[15:0];
        @(negedge clk);
        while (!req_ready && busy < 10) begin
            busy++;
            r1 = $urandom; r2 = $urandom;
            req_write = r1[16]; req_addr = r1[15:0]; req_wdata = r2[15:0];
            @(negedge clk);
        end
        req_valid = 1'b0;
        check(v.write ? "store_busy_cycles" : "load_busy_cycles", busy, v.write ? 1 : 3);
    endtask

    vec_t vecs[12];

    initial begin
        #100000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t v;
        vecs[0]  = '{write: 1'b1, addr: 16'h0010, wdata: 16'hBEEF, rdata: 16'h0000};
        vecs[1]  = '{write: 1'b0, addr: 16'h0010, wdata: 16'h0000, rdata: 16'hBEEF};
        vecs[2]  = '{write: 1'b1, addr: 16'h0003, wdata: 16'h1234, rdata: 16'h0000};
        vecs[3]  = '{write: 1'b0, addr: 16'h0003, wdata: 16'h0000, rdata: 16'h1234};
        vecs[4]  = '{write: 1'b1, addr: 16'h0004, wdata: 16'h5555, rdata: 16'h0000};
        vecs[5]  = '{write: 1'b0, addr: 16'h0004, wdata: 16'h0000, rdata: 16'h5555};
        vecs[6]  = '{write: 1'b1, addr: 16'hFFFF, wdata: 16'hA5A5, rdata: 16'h0000};
        vecs[7]  = '{write: 1'b0, addr: 16'hFFFF, wdata: 16'h0000, rdata: 16'hA5A5};
        vecs[8]  = '{write: 1'b0, addr: 16'h0000, wdata: 16'h0000, rdata: 16'h0000};
        vecs[9]  = '{write: 1'b1, addr: 16'h0010, wdata: 16'h0001, rdata: 16'h0000};
        vecs[10] = '{write: 1'b0, addr: 16'h0010, wdata: 16'h0000, rdata: 16'h0001};
        vecs[11] = '{write: 1'b0, addr: 16'h0003, wdata: 16'h0000, rdata: 16'h1234};

        // Reset held with a request pending: controller stays idle.
        req_valid = 1'b1; req_write = 1'b1; req_addr = 16'h0010; req_wdata = 16'hFFFF;
        repeat (3) @(negedge clk);
        check("rst_req_ready", req_ready, 1);
        check("rst_mem_enable", mem_enable, 0);
        check("rst_read_write", mem_read_write, 1);
        check("rst_mem_data", mem_data, 0);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_resp_rdata", resp_rdata, 0);
        check("rst_mem_address", mem_address, 0);
        req_valid = 1'b0;
        #2 reset = 1'b1;
        @(negedge clk);

        // Table: loads and stores issued back to back with req_valid held high between them.
        for (int i = 0; i < 12; i++) issue(vecs[i]);
        repeat (2) @(negedge clk);

        // Reset asserted in RD_ADDR: immediate idle, no response, no further strobes.
        req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h0010;
        @(posedge clk);
        #1;
        cur_addr = 16'h0010;
        req_valid = 1'b0;
        check("mid_load_enable_before", mem_enable, 1);
        reset = 1'b0;
        #1;
        check("mid_load_enable", mem_enable, 0);
        check("mid_load_read_write", mem_read_write, 1);
        check("mid_load_ready", req_ready, 1);
        check("mid_load_resp_valid", resp_valid, 0);
        check("mid_load_address", mem_address, 0);
        check("mid_load_rdata", resp_rdata, 0);
        repeat (2) @(negedge clk);
        #2 reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("post_abort_enable", mem_enable, 0);
        end

        v = '{write: 1'b0, addr: 16'h0000, wdata: 16'h0000, rdata: 16'h0000};
        issue(v);
        v = '{write: 1'b0, addr: 16'h0004, wdata: 16'h0000, rdata: 16'h5555};
        issue(v);

        repeat (5) @(negedge clk);
        check("scoreboard_drained", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
